// File: rtl/imm_pkg.sv
// Shared decode constants for the RISC-V immediate generator: opcodes,
// funct3 codes, the immediate format tag and small classification helpers.
package imm_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;

  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_SLTIU = 3'b011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_t;

  // BLTU (110) and BGEU (111) are the only branches with funct3[2:1] == 11.
  function automatic logic is_unsigned_branch(input logic [2:0] f3);
    return (f3[2:1] == 2'b11);
  endfunction

  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == F3_SLLI) || (f3 == F3_SRXI);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: instruction word to extended immediate,
// format tag and illegal flag, for XLEN 32 or 64.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ZEXT_UNSIGNED = 1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);

  localparam logic ZEXT = (ZEXT_UNSIGNED != 0);
  localparam logic RV64 = (XLEN == 64);

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("imm_decode: XLEN must be 32 or 64");
  end

  logic [4:0] opc;
  logic [2:0] f3;
  logic [XLEN-1:0] i_sext;
  logic [XLEN-1:0] i_zext;
  logic [XLEN-1:0] b_sext;
  logic [XLEN-1:0] b_zext;

  assign opc = inst[6:2];
  assign f3  = inst[14:12];

  assign i_sext = XLEN'(signed'(inst[31:20]));
  assign i_zext = XLEN'(inst[31:20]);
  assign b_sext = XLEN'(signed'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign b_zext = XLEN'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b1;
    if (inst[1:0] == 2'b11) begin
      case (opc)
        OPC_JALR: begin
          imm = i_sext; fmt = FMT_I; illegal = 1'b0;
        end
        OPC_LOAD: begin
          imm = (inst[14] && ZEXT) ? i_zext : i_sext;
          fmt = FMT_I; illegal = 1'b0;
        end
        OPC_OP_IMM: begin
          if (is_shift(f3)) begin
            // RV32 has only 5 shift bits; a set inst[25] is a reserved encoding.
            if (RV64) begin
              imm = XLEN'(inst[25:20]); fmt = FMT_SHAMT; illegal = 1'b0;
            end else if (!inst[25]) begin
              imm = XLEN'(inst[24:20]); fmt = FMT_SHAMT; illegal = 1'b0;
            end
          end else begin
            imm = ((f3 == F3_SLTIU) && ZEXT) ? i_zext : i_sext;
            fmt = FMT_I; illegal = 1'b0;
          end
        end
        OPC_OP_IMM32: begin
          if (RV64) begin
            if (is_shift(f3)) begin
              if (!inst[25]) begin
                imm = XLEN'(inst[24:20]); fmt = FMT_SHAMT; illegal = 1'b0;
              end
            end else begin
              imm = i_sext; fmt = FMT_I; illegal = 1'b0;
            end
          end
        end
        OPC_STORE: begin
          imm = XLEN'(signed'({inst[31:25], inst[11:7]}));
          fmt = FMT_S; illegal = 1'b0;
        end
        OPC_BRANCH: begin
          imm = (is_unsigned_branch(f3) && ZEXT) ? b_zext : b_sext;
          fmt = FMT_B; illegal = 1'b0;
        end
        OPC_LUI, OPC_AUIPC: begin
          imm = XLEN'(signed'({inst[31:12], 12'b0}));
          fmt = FMT_U; illegal = 1'b0;
        end
        OPC_JAL: begin
          imm = XLEN'(signed'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
          fmt = FMT_J; illegal = 1'b0;
        end
        default: begin
          imm = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: one instruction per cycle in, decoded
// immediate one cycle later, with a two-entry skid buffer for back-pressure.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int TAG_W         = 32,
  parameter int ZEXT_UNSIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // Handshake: a beat moves on a port exactly when valid & ready are both high
  // on a rising edge; valid never depends on ready, and a stalled output holds.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            dec_illegal;
  entry_t          in_entry;
  entry_t          out_q;
  entry_t          skid_q;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       in_ready_q;
  logic       in_fire;
  logic       out_fire;
  logic       load_out_in;
  logic       load_out_skid;
  logic       load_skid;

  imm_decode #(
    .XLEN          (XLEN),
    .ZEXT_UNSIGNED (ZEXT_UNSIGNED)
  ) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign in_entry.imm     = dec_imm;
  assign in_entry.fmt     = dec_fmt;
  assign in_entry.illegal = dec_illegal;
  assign in_entry.tag     = in_tag;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_nxt   = ST_ONE;
          load_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && !out_fire) begin
          state_nxt = ST_TWO;
          load_skid = 1'b1;
        end else if (in_fire && out_fire) begin
          load_out_in = 1'b1;
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          state_nxt     = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_TWO);
      if (load_out_in) begin
        out_q <= in_entry;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state != ST_EMPTY);
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three parameterisations share one input
// stream; decode vectors, a stalled tagged stream and a mid-stream reset.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_tag = '0;
  logic        out_ready = 1'b0;

  logic        r32, v32, ill32;
  logic [31:0] imm32, tag32;
  logic [2:0]  fmt32;
  logic        r32s, v32s, ill32s;
  logic [31:0] imm32s, tag32s;
  logic [2:0]  fmt32s;
  logic        r64, v64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic [2:0]  fmt64;

  int checks = 0;
  int errors = 0;
  int sent = 0;
  int delivered = 0;
  logic        seen_low = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] held;
  logic [63:0] exp_q[$];
  logic [63:0] got;
  logic [11:0] imm12;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ZEXT_UNSIGNED(1)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32));

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ZEXT_UNSIGNED(0)) d32s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32s),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(v32s), .out_ready(out_ready),
    .out_imm(imm32s), .out_fmt(fmt32s), .out_illegal(ill32s), .out_tag(tag32s));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ZEXT_UNSIGNED(1)) d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64));

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One instruction through all three instances; illegal is expected exactly when fmt is NONE.
  task automatic vec(input string name, input logic [31:0] inst,
                     input logic [31:0] e32, input logic [2:0] f32, input logic [31:0] e32s,
                     input logic [63:0] e64, input logic [2:0] f64);
    logic [31:0] tg;
    tg = inst ^ 32'hA5A5_0000;
    in_inst = inst; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({name, ".v32"}, 64'(v32), 64'd1);
    chk({name, ".imm32"}, 64'(imm32), 64'(e32));
    chk({name, ".fmt32"}, 64'(fmt32), 64'(f32));
    chk({name, ".ill32"}, 64'(ill32), 64'(f32 == 3'd0));
    chk({name, ".tag32"}, 64'(tag32), 64'(tg));
    chk({name, ".imm32s"}, 64'(imm32s), 64'(e32s));
    chk({name, ".fmt32s"}, 64'(fmt32s), 64'(f32));
    chk({name, ".ill32s"}, 64'(ill32s), 64'(f32 == 3'd0));
    chk({name, ".v64"}, 64'(v64), 64'd1);
    chk({name, ".imm64"}, imm64, e64);
    chk({name, ".fmt64"}, 64'(fmt64), 64'(f64));
    chk({name, ".ill64"}, 64'(ill64), 64'(f64 == 3'd0));
    chk({name, ".tag64"}, 64'(tag64), 64'(tg));
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst.out_valid", 64'(v32), 64'd0);
    chk("rst.in_ready", 64'(r32), 64'd1);
    chk("rst.out_imm", 64'(imm32), 64'd0);
    chk("rst.out_fmt", 64'(fmt32), 64'd0);
    chk("rst.out_illegal", 64'(ill32), 64'd0);
    chk("rst.out_tag", 64'(tag32), 64'd0);
    chk("rst.imm64", imm64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Decode vectors: name, inst, imm32, fmt, imm32 (sign-only), imm64, fmt64
    vec("addi_m1", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    vec("lui",     32'h123450B7, 32'h12345000, 3'd4, 32'h12345000, 64'h0000000012345000, 3'd4);
    vec("sltiu",   32'hFFF03093, 32'h00000FFF, 3'd1, 32'hFFFFFFFF, 64'h0000000000000FFF, 3'd1);
    vec("beq",     32'hFE000FE3, 32'hFFFFFFFE, 3'd3, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd3);
    vec("bltu",    32'hFE006FE3, 32'h00001FFE, 3'd3, 32'hFFFFFFFE, 64'h0000000000001FFE, 3'd3);
    vec("slli33",  32'h02109093, 32'h00000000, 3'd0, 32'h00000000, 64'd33,                3'd6);
    vec("lui_neg", 32'h80000037, 32'h80000000, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4);
    vec("low00",   32'h123450B4, 32'h00000000, 3'd0, 32'h00000000, 64'd0,                 3'd0);
    vec("jal_m4",  32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd5);
    vec("sw_m4",   32'hFE112E23, 32'hFFFFFFFC, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2);
    vec("addiw",   32'hFFF0009B, 32'h00000000, 3'd0, 32'h00000000, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    vec("slliw1",  32'h0010909B, 32'h00000000, 3'd0, 32'h00000000, 64'd1,                 3'd6);
    vec("lbu",     32'hFFF04083, 32'h00000FFF, 3'd1, 32'hFFFFFFFF, 64'h0000000000000FFF, 3'd1);
    vec("jalr_5",  32'h00508067, 32'h00000005, 3'd1, 32'h00000005, 64'd5,                 3'd1);
    vec("op_add",  32'h00208033, 32'h00000000, 3'd0, 32'h00000000, 64'd0,                 3'd0);

    // Tagged stream of 8 ADDIs with out_ready low for cycles 3..5
    for (int c = 0; c < 60 && delivered < 8; c++) begin
      @(posedge clk);
      #1;
      imm12 = 12'(sent * 300);
      in_valid  = (sent < 8);
      in_inst   = {imm12, 5'd2, 3'b000, 5'd1, 7'h13};
      in_tag    = 32'h100 + 32'(sent);
      out_ready = !(c >= 3 && c < 6);
      @(negedge clk);
      got = {tag32, imm32};
      if (prev_stall) chk("stream.stable", got, held);
      if (!r32 && !seen_low) begin
        seen_low = 1'b1;
        chk("stream.occupancy", 64'(sent - delivered), 64'd2);
      end
      if (v32 && out_ready) begin
        if (exp_q.size() == 0) chk("stream.extra", got, 64'd0 - 64'd1);
        else chk("stream.data", got, exp_q.pop_front());
        delivered++;
      end
      if (in_valid && r32) begin
        exp_q.push_back({in_tag, {{20{imm12[11]}}, imm12}});
        sent++;
      end
      prev_stall = v32 && !out_ready;
      held = got;
    end
    chk("stream.delivered", 64'(delivered), 64'd8);
    chk("stream.backpressure_seen", 64'(seen_low), 64'd1);
    chk("stream.queue_empty", 64'(exp_q.size()), 64'd0);

    // Fill both entries, then reset asynchronously mid-cycle
    @(posedge clk);
    #1 in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'hAA; out_ready = 1'b0;
    @(posedge clk);
    #1 in_inst = 32'h123450B7; in_tag = 32'hBB;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("pre_rst.out_valid", 64'(v32), 64'd1);
    chk("pre_rst.in_ready", 64'(r32), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 64'(v32), 64'd0);
    chk("arst.in_ready", 64'(r32), 64'd1);
    chk("arst.out_imm", 64'(imm32), 64'd0);
    chk("arst.out_tag", 64'(tag32), 64'd0);
    chk("arst.v64", 64'(v64), 64'd0);
    chk("arst.r32s", 64'(r32s), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst.out_valid", 64'(v32), 64'd0);
    chk("post_rst.in_ready", 64'(r32), 64'd1);
    chk("post_rst.r64", 64'(r64), 64'd1);
    chk("post_rst.v32s", 64'(v32s), 64'd0);
    vec("post_rst_addi", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    chk("post_rst.tag32s", 64'(tag32s), 64'(32'hFFF00093 ^ 32'hA5A5_0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised RISC-V immediate generator for the decode stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake and returns the extended immediate one cycle later, together with a format tag, an illegal flag and a passthrough tag. It supports XLEN 32/64 and a selectable unsigned-extension policy. A two-entry skid buffer gives full throughput under back-pressure with a registered `in_ready`.

## Interface
- `XLEN`, 32: operand width; only 32 or 64 are legal. Any other value is an elaboration error.
- `TAG_W`, 32: width of the sideband tag (typically the PC), carried unchanged.
- `ZEXT_UNSIGNED`, 1: 1 = zero-extend the immediates of LBU/LHU/LWU, SLTIU, BLTU and BGEU; 0 = RISC-V sign extension everywhere.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input instruction valid.
- `in_ready`  out  1  block can accept; registered.
- `in_inst`  in  32  instruction word.
- `in_tag`  in  TAG_W  sideband tag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts.
- `out_imm`  out  XLEN  extended immediate.
- `out_fmt`  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- `out_illegal`  out  1  encoding has no supported immediate.
- `out_tag`  out  TAG_W  tag of this result.

## Operation
- Illegal case:
  - Applies when `inst[1:0]!=2'b11` or the opcode `inst[6:2]` is unsupported.
  - Result is `imm=0`, `fmt=NONE`, `illegal=1`.
- JALR (11001): I format, `inst[31:20]` sign-extended.
- LOAD (00000): I format, `inst[31:20]`.
  - Zero-extended when `inst[14]=1` and `ZEXT_UNSIGNED=1`.
  - Otherwise sign-extended.
- OP-IMM (00100), shifts (`funct3` 001/101): SHAMT format, shift amount zero-extended.
  - XLEN=32: shift amount is `inst[24:20]`. `inst[25]=1` is illegal.
  - XLEN=64: shift amount is `inst[25:20]`.
- OP-IMM (00100), SLTIU (`funct3` 011): I format, zero-extended when `ZEXT_UNSIGNED=1`.
- OP-IMM (00100), all other `funct3`: I format, sign-extended.
- OP-IMM-32 (00110):
  - XLEN=64 only; illegal when XLEN=32.
  - Shifts: SHAMT format from `inst[24:20]`. `inst[25]=1` is illegal.
  - Otherwise: I format, sign-extended.
- STORE (01000): S format, `{inst[31:25],inst[11:7]}` sign-extended.
- BRANCH (11000): B format, `{inst[31],inst[7],inst[30:25],inst[11:8],1'b0}`.
  - Zero-extended when `inst[14:13]=2'b11` and `ZEXT_UNSIGNED=1`.
  - Otherwise sign-extended from bit 12.
- LUI/AUIPC (01101/00101): U format, `{inst[31:12],12'b0}`, sign-extended from bit 31 when XLEN=64.
- JAL (11011): J format, `{inst[31],inst[19:12],inst[20],inst[30:21],1'b0}`, sign-extended from bit 20.
- Decode is purely a function of `in_inst` and the parameters. The tag passes through untouched.

## Timing
- Reset (async assert, sync deassert is the system's job):
  - `out_valid=0`, `in_ready=1`, skid empty.
  - `out_imm`, `out_fmt`, `out_illegal` and `out_tag` are all 0.
- Input transfer occurs when `in_valid & in_ready`. Output transfer occurs when `out_valid & out_ready`.
- Latency: an instruction accepted in cycle N is presented in cycle N+1 when the output register is empty or draining.
- Throughput: 1 per cycle while `out_ready=1`.
- Buffer states: EMPTY, ONE (output register only), TWO (output register + skid).
  - EMPTY→ONE on input.
  - ONE→TWO on input while the output stalls.
  - TWO→ONE on output; the skid entry moves into the output register.
  - ONE→EMPTY on output with no input.
  - ONE→ONE on simultaneous input and output.
- `in_ready` is 0 exactly in TWO, registered from next state. Input is never dropped or duplicated.
- The output payload is stable while `out_valid & !out_ready`. Order is strictly FIFO.
- `in_valid` while `in_ready=0` is ignored; the upstream must hold.
- Reset asserted mid-stream: all buffered entries are discarded immediately and outputs go to their reset values.

## Structure
- Package `imm_pkg` holds:
  - opcode constants;
  - format enum `imm_fmt_t`;
  - `funct3` constants for shifts and SLTIU;
  - unsigned-branch detection.
- Sub-module `imm_decode` is combinational: `inst` → {imm, fmt, illegal}, parametrised by `XLEN` and `ZEXT_UNSIGNED`.
- Top level holds the output register, the skid register and the occupancy/`in_ready` logic.

## Test plan
- I format and U format:
  - XLEN=32, `0xFFF00093` (ADDI -1) → imm `0xFFFFFFFF`, fmt I, 1-cycle latency.
  - LUI `0x123450B7` → `0x12345000`.
- SLTIU `0xFFF03093`:
  - `ZEXT_UNSIGNED=1` → `0x00000FFF`.
  - `ZEXT_UNSIGNED=0` → `0xFFFFFFFF`.
- Branches:
  - BEQ `0xFE000FE3` → `0xFFFFFFFE`, fmt B.
  - BLTU `0xFE006FE3` with `ZEXT_UNSIGNED=1` → `0x00001FFE`.
- SLLI `0x02109093`:
  - XLEN=64 → imm 33, fmt SHAMT.
  - XLEN=32 → illegal, imm 0, fmt NONE.
- XLEN=64 sign extension:
  - LUI `0x80000037` → `0xFFFFFFFF80000000`.
  - `inst[1:0]=00` → illegal.
- Stream and reset:
  - Stream 8 tagged instructions back-to-back with `out_ready` low for 3 cycles mid-stream: `in_ready` falls after 2 accepts.
  - No loss, no reorder, and the payload stays stable during the stall.
  - Pulse `rst_n` low mid-stream: `out_valid` drops asynchronously and `in_ready=1` after release.
